// File: rtl/cpu_bus_ctrl_pkg.sv
// rtl/cpu_bus_ctrl_pkg.sv - shared decode constants, region type and trace entry width
package cpu_bus_ctrl_pkg;

    localparam int          RAM_AW_DEF      = 11;
    localparam int          TRACE_DEPTH_DEF = 8;
    localparam logic [15:0] ROM_BASE_DEF    = 16'h8000;
    localparam logic [7:0]  UNMAPPED_DATA   = 8'hFF;
    localparam int          TRACE_W         = 24;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_ROM,
        REGION_UNMAPPED
    } region_e;

    // RAM wins over ROM if a parameter set ever makes them overlap.
    function automatic region_e decode_region(input logic [15:0] addr,
                                              input int          ram_aw,
                                              input logic [15:0] rom_base);
        region_e r;
        if (32'(addr) < (32'd1 << ram_aw)) begin
            r = REGION_RAM;
        end else if (addr >= rom_base) begin
            r = REGION_ROM;
        end else begin
            r = REGION_UNMAPPED;
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// rtl/cpu_bus_ctrl_if.sv - CPU-side bus, ROM port and trace port bundle
interface cpu_bus_ctrl_if #(
    parameter int TRACE_DEPTH = 8
);
    localparam int CW = $clog2(TRACE_DEPTH) + 1;

    logic [15:0]   cpu_addr;
    logic [7:0]    cpu_odata;
    logic          cpu_rw;
    logic          cpu_clk2;
    logic [7:0]    cpu_idata;
    logic [15:0]   rom_addr;
    logic [7:0]    rom_data;
    logic          trace_valid;
    logic [15:0]   trace_addr;
    logic [7:0]    trace_data;
    logic          trace_ready;
    logic [CW-1:0] trace_count;
    logic          trace_overflow;

    modport master (
        output cpu_addr, cpu_odata, cpu_rw, cpu_clk2, rom_data, trace_ready,
        input  cpu_idata, rom_addr, trace_valid, trace_addr, trace_data,
               trace_count, trace_overflow
    );

    modport slave (
        input  cpu_addr, cpu_odata, cpu_rw, cpu_clk2, rom_data, trace_ready,
        output cpu_idata, rom_addr, trace_valid, trace_addr, trace_data,
               trace_count, trace_overflow
    );

endinterface

// File: rtl/cpu_bus_ctrl_trace_fifo.sv
// rtl/cpu_bus_ctrl_trace_fifo.sv - generic synchronous FIFO with count and sticky overflow
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0);
    assign do_pop  = pop & valid;
    // A simultaneous pop frees the slot this push needs, so full alone does not drop it.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - memory-side controller for cpu6502: RAM/ROM decode, phi2 write commit, write trace
module cpu_bus_ctrl
    import cpu_bus_ctrl_pkg::*;
#(
    parameter int          RAM_AW      = RAM_AW_DEF,
    parameter int          TRACE_DEPTH = TRACE_DEPTH_DEF,
    parameter logic [15:0] ROM_BASE    = ROM_BASE_DEF
) (
    input  logic         clk,
    input  logic         reset,
    cpu_bus_ctrl_if.slave bus
);

    localparam int CW = $clog2(TRACE_DEPTH) + 1;

    logic [7:0]         ram [0:(1 << RAM_AW)-1];
    logic               clk2_q;
    logic               phi2_rise;
    logic               wr_commit;
    logic               pop;
    logic               valid;
    logic [RAM_AW-1:0]  ram_idx;
    logic [TRACE_W-1:0] head;
    logic [CW-1:0]      count;
    logic               overflow;
    region_e            region;

    always_comb begin
        region = decode_region(bus.cpu_addr, RAM_AW, ROM_BASE);
    end

    assign ram_idx   = bus.cpu_addr[RAM_AW-1:0];
    assign phi2_rise = bus.cpu_clk2 & ~clk2_q;
    // clk2_q is held low during reset, so the rise term alone would fire while in reset.
    assign wr_commit = phi2_rise & ~bus.cpu_rw & reset;
    assign pop       = valid & bus.trace_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk2_q <= 1'b0;
        end else begin
            clk2_q <= bus.cpu_clk2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.cpu_idata <= UNMAPPED_DATA;
        end else begin
            case (region)
                REGION_RAM: bus.cpu_idata <= ram[ram_idx];
                REGION_ROM: bus.cpu_idata <= bus.rom_data;
                default:    bus.cpu_idata <= UNMAPPED_DATA;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit && region == REGION_RAM) begin
            ram[ram_idx] <= bus.cpu_odata;
        end
    end

    trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TRACE_W)
    ) u_trace_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (wr_commit),
        .din      ({bus.cpu_addr, bus.cpu_odata}),
        .pop      (pop),
        .dout     (head),
        .valid    (valid),
        .count    (count),
        .overflow (overflow)
    );

    assign bus.rom_addr       = bus.cpu_addr;
    assign bus.trace_valid    = valid;
    assign bus.trace_addr     = head[TRACE_W-1:8];
    assign bus.trace_data     = head[7:0];
    assign bus.trace_count    = count;
    assign bus.trace_overflow = overflow;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb/tb_cpu_bus_ctrl.sv - randomized bus cycles checked against a queue/array reference model
module tb_cpu_bus_ctrl;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    cpu_bus_ctrl_if #(.TRACE_DEPTH(DEPTH)) bus ();

    cpu_bus_ctrl #(.RAM_AW(11), .TRACE_DEPTH(DEPTH), .ROM_BASE(16'h8000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        if (a >= 16'hFFFC) return 8'h00;
        return a[7:0] ^ {a[14:8], 1'b1};
    endfunction

    assign bus.rom_data = rom_fn(bus.rom_addr);

    logic [7:0]  ram_m [int];
    logic [23:0] q_m [$];
    bit          ovf_m = 0;
    bit          prev_clk2 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] exp_idata;
        bit         known;
        bit         rise;
        int         a;
        known = 1;
        exp_idata = 8'hFF;
        if (!reset) begin
            q_m.delete();
            ovf_m = 0;
            prev_clk2 = 0;
        end else begin
            a = int'(bus.cpu_addr);
            if (a < 2048) begin
                known = ram_m.exists(a);
                if (known) exp_idata = ram_m[a];
            end else if (a >= 32'h8000) begin
                exp_idata = rom_fn(bus.cpu_addr);
            end
            rise = bus.cpu_clk2 && !prev_clk2;
            prev_clk2 = bus.cpu_clk2;
            if (bus.trace_ready && q_m.size() > 0) void'(q_m.pop_front());
            if (rise && !bus.cpu_rw) begin
                if (a < 2048) ram_m[a] = bus.cpu_odata;
                if (q_m.size() < DEPTH) q_m.push_back({bus.cpu_addr, bus.cpu_odata});
                else ovf_m = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (known) check("idata", bus.cpu_idata, exp_idata);
        check("count", bus.trace_count, q_m.size());
        check("valid", bus.trace_valid, q_m.size() != 0);
        check("overflow", bus.trace_overflow, ovf_m);
        if (q_m.size() != 0) begin
            check("head_addr", bus.trace_addr, q_m[0][23:8]);
            check("head_data", bus.trace_data, q_m[0][7:0]);
        end
    endtask

    function automatic logic rdy(input int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return (mode == 3);
    endfunction

    // mode: 0 never pop, 1 pop only on the phi2 rise clock, 2 random, 3 always pop
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw, input int mode);
        bus.cpu_addr = a;
        bus.cpu_odata = d;
        bus.cpu_rw = rw;
        bus.cpu_clk2 = 1'b0;
        bus.trace_ready = rdy(mode);
        tick();
        bus.trace_ready = rdy(mode);
        tick();
        bus.cpu_clk2 = 1'b1;
        bus.trace_ready = (mode == 1) ? 1'b1 : rdy(mode);
        tick();
        bus.trace_ready = rdy(mode);
        tick();
        bus.trace_ready = rdy(mode);
        tick();
        bus.cpu_clk2 = 1'b0;
        bus.trace_ready = 1'b0;
    endtask

    task automatic drain();
        bus.cpu_clk2 = 1'b0;
        bus.cpu_rw = 1'b1;
        bus.trace_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        bus.trace_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]  acc;
        logic        c;
        logic        nc;
        logic [15:0] a;
        bus.cpu_addr = 16'h4000;
        bus.cpu_odata = 8'h00;
        bus.cpu_rw = 1'b1;
        bus.cpu_clk2 = 1'b0;
        bus.trace_ready = 1'b0;
        @(negedge clk);
        tick();
        check("rst_idata", bus.cpu_idata, 8'hFF);
        reset = 1'b1;
        tick();

        // LDA #$FF; ROL A x4 (carry starts clear); STA $99
        acc = 8'hFF;
        c = 1'b0;
        repeat (4) begin
            nc = acc[7];
            acc = {acc[6:0], c};
            c = nc;
        end
        bus_cycle(16'hFFFC, 8'h00, 1'b1, 0);
        check("vector_lo", bus.cpu_idata, 8'h00);
        bus_cycle(16'h0099, acc, 1'b0, 0);
        check("sta_valid", bus.trace_valid, 1'b1);
        check("sta_addr", bus.trace_addr, 16'h0099);
        check("sta_data", bus.trace_data, 8'hF7);
        check("sta_count", bus.trace_count, 1);
        bus_cycle(16'h0099, 8'h00, 1'b1, 3);
        check("ram_99", bus.cpu_idata, 8'hF7);

        bus_cycle(16'h0123, 8'h5A, 1'b0, 3);
        bus_cycle(16'h0123, 8'h00, 1'b1, 3);
        check("raw_0123", bus.cpu_idata, 8'h5A);

        drain();
        bus_cycle(16'h0000, 8'h77, 1'b0, 3);
        bus_cycle(16'h4000, 8'h00, 1'b1, 3);
        check("unmapped_rd", bus.cpu_idata, 8'hFF);
        drain();
        bus_cycle(16'h4000, 8'hC3, 1'b0, 0);
        check("unm_tr_addr", bus.trace_addr, 16'h4000);
        check("unm_tr_data", bus.trace_data, 8'hC3);
        bus_cycle(16'h0000, 8'h00, 1'b1, 3);
        check("ram0_kept", bus.cpu_idata, 8'h77);

        drain();
        for (int i = 0; i < DEPTH; i++) bus_cycle(16'h0020 + 16'(i), 8'($urandom), 1'b0, 0);
        bus_cycle(16'h0030, 8'h33, 1'b0, 1);
        check("full_pp_count", bus.trace_count, DEPTH);
        check("full_pp_ovf", bus.trace_overflow, 1'b0);
        check("full_pp_head", bus.trace_addr, 16'h0021);

        drain();
        for (int i = 0; i < 9; i++) bus_cycle(16'h0010 + 16'(i), 8'h10 + 8'(i), 1'b0, 0);
        check("ovf_count", bus.trace_count, DEPTH);
        check("ovf_flag", bus.trace_overflow, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            check("ovf_pop_addr", bus.trace_addr, 16'h0010 + 16'(i));
            check("ovf_pop_data", bus.trace_data, 8'h10 + 8'(i));
            bus.trace_ready = 1'b1;
            tick();
            bus.trace_ready = 1'b0;
        end
        check("ovf_empty", bus.trace_valid, 1'b0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 4))
                0: a = 16'($urandom_range(0, 63));
                1: a = 16'($urandom_range(0, 2047));
                2: a = 16'h8000 + 16'($urandom_range(0, 32767));
                3: a = 16'h0800 + 16'($urandom_range(0, 16'h77FF));
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 16'h07FF;
                        1: a = 16'h0800;
                        2: a = 16'h7FFF;
                        default: a = 16'h8000;
                    endcase
                end
            endcase
            bus_cycle(a, 8'($urandom), 1'($urandom_range(0, 1)), 2);
        end

        drain();
        bus_cycle(16'h0200, 8'h11, 1'b0, 3);
        for (int i = 0; i < 3; i++) bus_cycle(16'h0300 + 16'(i), 8'($urandom), 1'b0, 0);
        bus.cpu_addr = 16'h0200;
        bus.cpu_rw = 1'b1;
        bus.cpu_clk2 = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("async_count", bus.trace_count, 0);
        check("async_valid", bus.trace_valid, 1'b0);
        check("async_idata", bus.cpu_idata, 8'hFF);
        bus.cpu_clk2 = 1'b0;
        bus.cpu_rw = 1'b0;
        bus.cpu_odata = 8'hAB;
        tick();
        bus.cpu_clk2 = 1'b1;
        tick();
        bus.cpu_clk2 = 1'b0;
        bus.cpu_rw = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        bus_cycle(16'h0400, 8'h5C, 1'b0, 0);
        check("post_rst_addr", bus.trace_addr, 16'h0400);
        check("post_rst_cnt", bus.trace_count, 1);
        bus_cycle(16'h0200, 8'h00, 1'b1, 0);
        check("post_rst_0200", bus.cpu_idata, 8'h11);
        bus_cycle(16'h0123, 8'h00, 1'b1, 0);
        check("post_rst_0123", bus.cpu_idata, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_ctrl.md
Name: cpu_bus_ctrl

Overview:
- Memory-side bus controller that sits directly downstream of cpu6502's external bus (addr, odata, rw, clk2) and drives the CPU's idata.
- Decodes the 64 KiB address space into internal RAM, an external ROM port and an unmapped region.
- Commits CPU writes on the rising edge of phi2 (clk2).
- Logs every CPU write into a small trace FIFO, so benches and debug logic can check stores (e.g. STA $99) without probing CPU internals.

Parameters:
- RAM_AW, 11, RAM address width; RAM covers $0000..(2^RAM_AW - 1), default $0000-$07FF.
- TRACE_DEPTH, 8, trace FIFO entries; power of two, minimum 2.
- ROM_BASE, 16'h8000, first ROM address; ROM covers ROM_BASE..$FFFF.

Ports:
- clk  in  1  system clock, same clock that drives cpu6502.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cpu_addr  in  16  CPU address bus.
- cpu_odata  in  8  CPU write data.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_clk2  in  1  CPU phi2 output.
- cpu_idata  out  8  read data to the CPU.
- rom_addr  out  16  address to the external ROM; equals cpu_addr.
- rom_data  in  8  ROM data; combinational from rom_addr.
- trace_valid  out  1  FIFO non-empty.
- trace_addr  out  16  head entry address.
- trace_data  out  8  head entry data.
- trace_ready  in  1  pop request; takes effect when trace_valid is 1.
- trace_count  out  $clog2(TRACE_DEPTH)+1  number of entries held.
- trace_overflow  out  1  sticky; set when a write is dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - cpu_idata=8'hFF, trace_valid=0, trace_count=0, trace_overflow=0.
  - FIFO pointers cleared; phi2 edge register cleared to 0.
  - RAM contents are not reset.
- Phi2 edge detect:
  - clk2_q <= cpu_clk2 every clk.
  - phi2_rise = cpu_clk2 & ~clk2_q.
  - Exactly one rise is detected per phi2 high phase.
- Region decode (combinational on cpu_addr):
  - RAM if cpu_addr < 2^RAM_AW.
  - ROM if cpu_addr >= ROM_BASE.
  - Otherwise unmapped.
- Read path:
  - Registered every clk.
  - cpu_idata <= RAM[cpu_addr[RAM_AW-1:0]] (RAM), rom_data (ROM) or 8'hFF (unmapped).
  - Latency 1 clk from an address change. Correct data is therefore presented well before the phi2 falling edge, where the CPU samples.
  - The read path updates regardless of cpu_rw.
- Write commit:
  - On phi2_rise with cpu_rw=0: if the address decodes to RAM, RAM[cpu_addr] <= cpu_odata.
  - Writes to ROM or unmapped addresses are ignored by memory but still traced.
- Read-after-write: a read of the same RAM address in the following bus cycle returns the new value. Synchronous RAM with read-first behaviour is acceptable, because the next bus cycle is several clk later.
- Trace FIFO:
  - push = phi2_rise & ~cpu_rw; entry = {cpu_addr, cpu_odata}.
  - pop = trace_valid & trace_ready.
  - Head entry is presented combinationally on trace_addr/trace_data.
  - When trace_valid=0, trace_addr and trace_data are don't-care.
  - Pointers wrap modulo TRACE_DEPTH.
  - trace_count is updated in the same clk as push/pop: +1, -1 or unchanged.
- FIFO boundaries:
  - push while full and no pop: entry dropped, trace_overflow <= 1, count stays TRACE_DEPTH.
  - push and pop together while full: both occur, count unchanged, no overflow.
  - push and pop together while count=1: count stays 1, new entry becomes head.
  - pop while empty: ignored.
  - trace_overflow clears only on reset.
- Reset mid-operation: an in-flight write is discarded if reset asserts before its phi2_rise. After release, the first rise of cpu_clk2 is detected normally.

Decomposition:
- Shared package/include: region decode constants (RAM_AW default, ROM_BASE default, UNMAPPED_DATA = 8'hFF) and the trace entry width (24).
- One sub-module, trace_fifo: a generic synchronous FIFO with async active-low reset, DEPTH and WIDTH parameters, push/pop, count and overflow.
- RAM array, decode and phi2 edge logic stay in cpu_bus_ctrl.

Test Plan:
- Run LDA #$FF; ROLA x4; STA $99 with a ROM image and reset vector $0000 -> trace_valid=1, trace_addr=16'h0099, trace_data=8'hF7, trace_count=1; RAM[$99]=8'hF7.
- Write $5A to $0123, then read $0123 -> cpu_idata=8'h5A one clk after the address is presented, and stable at the phi2 fall.
- Read $FFFC with rom_data=8'h00 -> cpu_idata=8'h00; read $4000 (unmapped) -> 8'hFF; write to $4000 -> RAM unchanged, trace entry {$4000, data}.
- 9 writes ($10..$18 with data = address), no pops -> count=8, trace_overflow=1, pops return $10..$17 in order, then trace_valid=0.
- FIFO full with trace_ready=1 during the next write -> count stays 8, trace_overflow stays 0, oldest entry removed.
- Assert reset with 3 entries queued and cpu_clk2 high -> trace_count=0, trace_valid=0, cpu_idata=8'hFF immediately (asynchronous). After release, the first write at the next phi2 rise is traced, and RAM data written before reset is still readable.
